hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage core.
- Generates the PC write enable, the IF/ID write enable and flush, and the ID/EX bubble request.
- Covers three hazards: load-use, taken branch resolved in EX, and structural/HI-LO stalls of the iterative mul/div unit.
- Tracks mul/div occupancy with an internal countdown and keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_ctrl_pkg.sv | 38 +++
 rtl/hazard_ctrl_md_scoreboard.sv | 41 ++++
 rtl/hazard_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register-index width,
// mul/div latency defaults and the encoding of the pipeline control bundle.
package hazard_ctrl_pkg;

    localparam int REG_W       = 5;
    localparam int MD_CNT_W    = 4;
    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 12;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        ACT_RUN,
        ACT_STALL,
        ACT_FLUSH,
        ACT_RESET
    } act_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic md_issue;
    } ctrl_t;

    // Hold front end and inject a bubble; also the state presented during reset.
    localparam ctrl_t CTRL_HOLD  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam ctrl_t CTRL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam ctrl_t CTRL_RUN   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    function automatic logic src_match(input logic uses,
                                       input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_scoreboard.sv
// Mul/div occupancy tracker: a 4-bit countdown loaded with the op latency on
// issue and decremented every cycle until the unit is free again.
module hazard_ctrl_md_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic clock,
    input  logic rst,
    input  logic md_issue,
    input  logic md_is_div,
    output logic md_busy
);

    localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MUL_LAT);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD = MD_CNT_W'(DIV_LAT);

    logic [MD_CNT_W-1:0] cnt_reg;
    logic [MD_CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (md_issue) begin
            cnt_next = md_is_div ? DIV_LOAD : MUL_LOAD;
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign md_busy = (cnt_reg != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: resolves load-use, taken-branch and mul/div
// structural hazards into PC/IF-ID/ID-EX controls and counts stall cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_md_valid,
    input  logic             id_md_is_div,
    input  logic             id_hilo_read,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_issue,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    logic       load_use;
    logic       md_hazard;
    logic       stall;
    act_e       act;
    ctrl_t      ctrl;
    logic       md_busy_int;
    logic [CNT_W-1:0] stall_cnt_reg;

    assign load_use  = ex_mem_read && (ex_rt != ZERO_REG) &&
                       (src_match(id_uses_rs, id_rs, ex_rt) ||
                        src_match(id_uses_rt, id_rt, ex_rt));
    assign md_hazard = md_busy_int && (id_md_valid || id_hilo_read);
    assign stall     = load_use || md_hazard;

    // A taken branch wins over any stall: the ID instruction is wrong-path.
    always_comb begin
        act = ACT_RUN;
        if (rst) begin
            act = ACT_RESET;
        end else if (ex_branch_taken) begin
            act = ACT_FLUSH;
        end else if (stall) begin
            act = ACT_STALL;
        end
    end

    always_comb begin
        ctrl = CTRL_HOLD;
        case (act)
            ACT_FLUSH: ctrl = CTRL_FLUSH;
            ACT_RUN: begin
                ctrl          = CTRL_RUN;
                ctrl.md_issue = id_md_valid;
            end
            default:   ctrl = CTRL_HOLD;
        endcase
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign md_issue    = ctrl.md_issue;

    hazard_ctrl_md_scoreboard #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_scoreboard (
        .clock     (clock),
        .rst       (rst),
        .md_issue  (ctrl.md_issue),
        .md_is_div (id_md_is_div),
        .md_busy   (md_busy_int)
    );

    assign md_busy = md_busy_int && !rst;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if ((act == ACT_STALL) && !(&stall_cnt_reg)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cycles = stall_cnt_reg;

endmodule
